// File: rtl/handshake_buffer_fifo.sv
// Elastic FIFO buffer between dataflow units. ins_ready is derived only from
// registered occupancy, so the ready chain from the consumer is broken here.
module handshake_buffer_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic [CNT_WIDTH-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  full, push, pop;

   assign full       = (count_q == CNT_WIDTH'(DEPTH));
   // rst gates ready so nothing is accepted while reset is held low
   assign ins_ready  = ~full & rst;
   assign outs_valid = (count_q != '0);
   assign outs       = mem_q[rd_ptr_q];
   assign count      = count_q;

   assign push = ins_valid & ins_ready;
   assign pop  = outs_valid & outs_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_WIDTH'(1);
         2'b01:   count_d = count_q - CNT_WIDTH'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left unreset; occupancy alone qualifies it
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= ins;
   end

endmodule

// File: tb/tb_handshake_buffer_fifo.sv
// Directed bench for handshake_buffer_fifo with a queue scoreboard fed by
// accepted pushes and drained by observed pops.
module tb_handshake_buffer_fifo;

   localparam int DW  = 17;
   localparam int DEP = 4;
   localparam int CW  = $clog2(DEP) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] ins;
   logic          ins_valid;
   logic          ins_ready;
   logic [DW-1:0] outs;
   logic          outs_valid;
   logic          outs_ready;
   logic [CW-1:0] count;

   int tests = 0;
   int fails = 0;
   logic [DW-1:0] sb_q [$];

   handshake_buffer_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
      .clk(clk), .rst(rst),
      .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
      .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Inputs change at posedge+2; sampling at negedge predicts the next edge.
   logic          pv = 1'b0, pr = 1'b0;
   logic [DW-1:0] pins = '0;
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (pv && !pr) begin
            assert (ins_valid === 1'b1 && ins === pins) else begin
               fails++;
               $error("FAIL proto_hold observed=%0h/%0b expected=%0h/1", ins, ins_valid, pins);
            end
         end
         if (ins_valid && ins_ready) sb_q.push_back(ins);
         if (outs_valid && outs_ready) begin
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $error("FAIL pop_empty_sb observed=%0h expected=none", outs);
            end else begin
               automatic logic [DW-1:0] e = sb_q.pop_front();
               assert (outs === e) else begin
                  fails++;
                  $error("FAIL pop_data observed=%0h expected=%0h", outs, e);
               end
            end
         end
      end
      pv   = ins_valid;
      pr   = ins_ready;
      pins = ins;
   end

   initial begin
      rst = 1'b0; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_ready", ins_ready, 0);
         chk("rst_valid", outs_valid, 0);
         chk("rst_count", count, 0);
         cyc(1);
      end
      rst = 1'b1;
      #1;
      chk("rel_ready", ins_ready, 1);
      chk("rel_valid", outs_valid, 0);

      // single token
      cyc(1);
      ins = 17'h1FB3C; ins_valid = 1'b1; outs_ready = 1'b1;
      cyc(1);
      ins_valid = 1'b0;
      chk("single_valid", outs_valid, 1);
      chk("single_data", outs, 32'h1FB3C);
      chk("single_cnt1", count, 1);
      cyc(1);
      chk("single_cnt0", count, 0);
      chk("single_empty", outs_valid, 0);

      // fill to full
      outs_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         ins = DW'(i); ins_valid = 1'b1;
         cyc(1);
      end
      chk("full_cnt", count, 4);
      chk("full_ready", ins_ready, 0);
      ins = DW'(5); ins_valid = 1'b1;
      cyc(2);
      chk("full_hold_cnt", count, 4);
      chk("full_hold_rdy", ins_ready, 0);
      chk("full_head", outs, 1);
      outs_ready = 1'b1;
      cyc(1);
      outs_ready = 1'b0;
      chk("full_pop_rdy", ins_ready, 1);
      chk("full_pop_cnt", count, 3);
      cyc(1);
      ins_valid = 1'b0;
      chk("full_5th_cnt", count, 4);
      outs_ready = 1'b1;
      cyc(4);
      chk("drain_cnt", count, 0);

      // streaming with wrap-around
      for (int i = 0; i < 20; i++) begin
         ins = DW'(i); ins_valid = 1'b1;
         chk("stream_ready", ins_ready, 1);
         cyc(1);
      end
      ins_valid = 1'b0;
      chk("stream_cnt", count, 1);
      cyc(1);
      chk("stream_drain", count, 0);

      // backpressure stall
      outs_ready = 1'b0;
      ins = 17'h000A1; ins_valid = 1'b1; cyc(1);
      ins = 17'h000A2; cyc(1);
      ins_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_data", outs, 32'hA1);
         chk("stall_valid", outs_valid, 1);
         chk("stall_cnt", count, 2);
         cyc(1);
      end
      outs_ready = 1'b1;
      cyc(2);
      chk("stall_drain", count, 0);

      // reset mid-operation
      outs_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         ins = DW'(i * 'h11); ins_valid = 1'b1;
         cyc(1);
      end
      ins_valid = 1'b0;
      chk("mid_cnt3", count, 3);
      #1;
      rst = 1'b0;
      sb_q.delete();
      #1;
      chk("mid_valid", outs_valid, 0);
      chk("mid_cnt", count, 0);
      chk("mid_ready", ins_ready, 0);
      cyc(2);
      rst = 1'b1;
      ins = 17'h0AAAA; ins_valid = 1'b1; cyc(1);
      chk("post_head", outs, 32'h0AAAA);
      ins = 17'h0BBBB; cyc(1);
      ins_valid = 1'b0; outs_ready = 1'b1;
      cyc(3);
      chk("post_cnt", count, 0);
      chk("sb_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
